// File: rtl/multi_channel_fifo_queue_pkg.sv
// Shared constants and types for the multi-channel FIFO queue: default sizes,
// storage-type selectors and the grant state encoding.
package multi_channel_fifo_queue_pkg;

    localparam int DEFAULT_NUM_CHANNELS     = 4;
    localparam int DEFAULT_CHANNEL_ID_WIDTH = 2;
    localparam int DEFAULT_QUEUE_SIZE       = 16;
    localparam int DEFAULT_PTR_WIDTH        = 4;
    localparam int DEFAULT_ENTRY_WIDTH      = 32;

    localparam string STORAGE_LUTRAM   = "LUTRAM";
    localparam string STORAGE_REGISTER = "REGISTER";

    typedef enum logic {
        GRANT_IDLE   = 1'b0,
        GRANT_ACTIVE = 1'b1
    } grant_state_e;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1) % modulus;
    endfunction

endpackage

// File: rtl/multi_channel_fifo_queue_if.sv
// Bundle of the per-channel input handshake, shared output port, flush and
// status signals of the multi-channel FIFO queue.
interface multi_channel_fifo_queue_if
    import multi_channel_fifo_queue_pkg::*;
#(
    parameter int NUM_CHANNELS               = DEFAULT_NUM_CHANNELS,
    parameter int CHANNEL_ID_WIDTH           = DEFAULT_CHANNEL_ID_WIDTH,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = DEFAULT_PTR_WIDTH,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH
);
    logic [NUM_CHANNELS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0]    request_in;
    logic [NUM_CHANNELS-1:0]                               request_valid_in;
    logic [NUM_CHANNELS-1:0]                               issue_ack_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                 request_out;
    logic [CHANNEL_ID_WIDTH-1:0]                           request_channel_out;
    logic                                                  request_valid_out;
    logic                                                  issue_ack_in;
    logic [NUM_CHANNELS-1:0]                               flush_in;
    logic [NUM_CHANNELS-1:0]                               is_empty_out;
    logic [NUM_CHANNELS-1:0]                               is_full_out;
    logic [NUM_CHANNELS*(QUEUE_PTR_WIDTH_IN_BITS+1)-1:0]   occupancy_packed_out;

    modport master (
        output request_in, request_valid_in, issue_ack_in, flush_in,
        input  issue_ack_out, request_out, request_channel_out, request_valid_out,
        input  is_empty_out, is_full_out, occupancy_packed_out
    );

    modport slave (
        input  request_in, request_valid_in, issue_ack_in, flush_in,
        output issue_ack_out, request_out, request_channel_out, request_valid_out,
        output is_empty_out, is_full_out, occupancy_packed_out
    );
endinterface

// File: rtl/multi_channel_fifo_queue_storage.sv
// One channel's FIFO: pointers, occupancy count and entry storage with
// write/read/flush strobes. The head entry is read asynchronously.
module multi_channel_fifo_queue_storage
    import multi_channel_fifo_queue_pkg::*;
#(
    parameter int    PTR_W        = DEFAULT_PTR_WIDTH,
    parameter int    DATA_W       = DEFAULT_ENTRY_WIDTH,
    parameter int    DEPTH        = DEFAULT_QUEUE_SIZE,
    parameter string STORAGE_TYPE = "LUTRAM"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head_data,
    output logic [PTR_W:0]    o_count
);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_fire;

    assign w_wr_fire = i_wr_en & ~i_flush;

    // Flush wins over any write or pop on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (STORAGE_TYPE == STORAGE_REGISTER) begin : g_reg_storage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
                end else if (w_wr_fire) begin
                    r_mem[r_wr_ptr] <= i_wr_data;
                end
            end
        end else begin : g_lutram_storage
            always_ff @(posedge clk) begin
                if (w_wr_fire) r_mem[r_wr_ptr] <= i_wr_data;
            end
        end
    endgenerate

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/multi_channel_fifo_queue.sv
// N independent FIFOs draining through one output port under a locked
// round-robin grant, with per-channel flush and occupancy reporting.
module multi_channel_fifo_queue
    import multi_channel_fifo_queue_pkg::*;
#(
    parameter int    NUM_CHANNELS               = DEFAULT_NUM_CHANNELS,
    parameter int    CHANNEL_ID_WIDTH           = DEFAULT_CHANNEL_ID_WIDTH,
    parameter int    QUEUE_SIZE                 = DEFAULT_QUEUE_SIZE,
    parameter int    QUEUE_PTR_WIDTH_IN_BITS    = DEFAULT_PTR_WIDTH,
    parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
    parameter string STORAGE_TYPE               = "LUTRAM"
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    multi_channel_fifo_queue_if.slave      bus
);
    localparam int PW = QUEUE_PTR_WIDTH_IN_BITS;
    localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;

    grant_state_e                r_state, w_state_next;
    logic [CHANNEL_ID_WIDTH-1:0] r_grant_id, w_grant_id_next;
    logic [CHANNEL_ID_WIDTH-1:0] r_rr_ptr, w_rr_ptr_next;

    logic [NUM_CHANNELS-1:0]        w_wr;
    logic [NUM_CHANNELS-1:0]        w_rd;
    logic [NUM_CHANNELS-1:0]        w_empty;
    logic [NUM_CHANNELS-1:0]        w_full;
    logic [NUM_CHANNELS-1:0]        w_cand;
    logic [NUM_CHANNELS*(PW+1)-1:0] w_occ;
    logic [PW:0]                    w_count [NUM_CHANNELS];
    logic [DW-1:0]                  w_head  [NUM_CHANNELS];
    logic                           w_grant_flushed;
    logic                           w_pop;
    logic                           w_found;
    int                             w_start;
    int                             w_idx;

    assign w_grant_flushed = (r_state == GRANT_ACTIVE) & bus.flush_in[r_grant_id];
    assign w_pop           = (r_state == GRANT_ACTIVE) & bus.issue_ack_in & ~w_grant_flushed;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign w_wr[gi] = bus.request_valid_in[gi] & ~w_full[gi] & ~bus.flush_in[gi];
            assign w_rd[gi] = w_pop & (r_grant_id == CHANNEL_ID_WIDTH'(gi));

            multi_channel_fifo_queue_storage #(
                .PTR_W        (PW),
                .DATA_W       (DW),
                .DEPTH        (QUEUE_SIZE),
                .STORAGE_TYPE (STORAGE_TYPE)
            ) u_storage (
                .clk         (clk_in),
                .rst         (reset_in),
                .i_wr_en     (w_wr[gi]),
                .i_wr_data   (bus.request_in[gi*DW +: DW]),
                .i_rd_en     (w_rd[gi]),
                .i_flush     (bus.flush_in[gi]),
                .o_head_data (w_head[gi]),
                .o_count     (w_count[gi])
            );

            assign w_empty[gi]              = (w_count[gi] == '0);
            assign w_full[gi]               = (w_count[gi] == (PW+1)'(QUEUE_SIZE));
            assign w_occ[gi*(PW+1) +: PW+1] = w_count[gi];
        end
    endgenerate

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= GRANT_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_id_next;
            r_rr_ptr   <= w_rr_ptr_next;
        end
    end

    // Candidates are pre-edge non-empty channels; a channel being drained of its
    // last entry or being flushed this edge cannot win.
    always_comb begin
        w_state_next    = r_state;
        w_grant_id_next = r_grant_id;
        w_rr_ptr_next   = r_rr_ptr;
        w_found         = 1'b0;
        w_idx           = 0;
        w_cand          = ~w_empty & ~bus.flush_in;
        if (w_pop && w_count[r_grant_id] == (PW+1)'(1)) w_cand[r_grant_id] = 1'b0;
        w_start = (r_state == GRANT_IDLE) ? int'(r_rr_ptr)
                                          : wrap_inc(int'(r_grant_id), NUM_CHANNELS);

        if (w_pop) w_rr_ptr_next = CHANNEL_ID_WIDTH'(wrap_inc(int'(r_grant_id), NUM_CHANNELS));

        if (w_grant_flushed) begin
            w_state_next = GRANT_IDLE;
        end else if (r_state == GRANT_IDLE || w_pop) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                w_idx = (w_start + k) % NUM_CHANNELS;
                if (!w_found && w_cand[CHANNEL_ID_WIDTH'(w_idx)]) begin
                    w_found         = 1'b1;
                    w_grant_id_next = CHANNEL_ID_WIDTH'(w_idx);
                end
            end
            w_state_next = w_found ? GRANT_ACTIVE : GRANT_IDLE;
        end
    end

    assign bus.issue_ack_out        = w_wr;
    assign bus.is_empty_out         = w_empty;
    assign bus.is_full_out          = w_full;
    assign bus.occupancy_packed_out = w_occ;
    assign bus.request_valid_out    = (r_state == GRANT_ACTIVE);
    assign bus.request_channel_out  = r_grant_id;
    assign bus.request_out          = (r_state == GRANT_ACTIVE) ? w_head[r_grant_id] : '0;

endmodule

// File: tb/tb_multi_channel_fifo_queue.sv
// Directed bench for multi_channel_fifo_queue: reset state, fill-to-full,
// round-robin drain, flush of the granted channel, full refusal, grant gap.
module tb_multi_channel_fifo_queue;
    import multi_channel_fifo_queue_pkg::*;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int PW = 4;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    multi_channel_fifo_queue_if #(
        .NUM_CHANNELS(N), .CHANNEL_ID_WIDTH(CW),
        .QUEUE_PTR_WIDTH_IN_BITS(PW), .SINGLE_ENTRY_WIDTH_IN_BITS(DW)
    ) bus ();

    multi_channel_fifo_queue #(
        .NUM_CHANNELS(N), .CHANNEL_ID_WIDTH(CW), .QUEUE_SIZE(16),
        .QUEUE_PTR_WIDTH_IN_BITS(PW), .SINGLE_ENTRY_WIDTH_IN_BITS(DW),
        .STORAGE_TYPE("LUTRAM")
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
            $display("check %-12s actual=%0h expected=%0h ok", tag, actual, expected);
        end else begin
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [PW:0] occ(input int ch);
        logic [N*(PW+1)-1:0] v;
        v = bus.occupancy_packed_out;
        return v[ch*(PW+1) +: PW+1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.request_in       = '0;
        bus.request_valid_in = '0;
        bus.issue_ack_in     = 1'b0;
        bus.flush_in         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        bus.request_in[ch*DW +: DW] = d;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        idle_inputs();
        #2;

        // Reset state
        do_reset();
        check_eq("rst_empty", 64'(bus.is_empty_out), 64'hF);
        check_eq("rst_full",  64'(bus.is_full_out), 64'h0);
        check_eq("rst_valid", 64'(bus.request_valid_out), 64'h0);
        check_eq("rst_occ",   64'(bus.occupancy_packed_out), 64'h0);
        check_eq("rst_data",  64'(bus.request_out), 64'h0);
        check_eq("rst_chan",  64'(bus.request_channel_out), 64'h0);
        bus.request_valid_in = 4'b1010;
        #1;
        check_eq("idle_ack", 64'(bus.issue_ack_out), 64'hA);
        idle_inputs();

        // Fill channel 0 to full with no consumer ack
        for (int i = 0; i < 16; i++) begin
            bus.request_valid_in = 4'b0001;
            set_data(0, 32'hA0 + 32'(i));
            #1;
            check_eq($sformatf("fill_ack%0d", i), 64'(bus.issue_ack_out[0]), 64'h1);
            step();
        end
        check_eq("fill_full", 64'(bus.is_full_out), 64'h1);
        check_eq("fill_occ0", 64'(occ(0)), 64'd16);
        set_data(0, 32'hB0);
        #1;
        check_eq("fill_refuse", 64'(bus.issue_ack_out[0]), 64'h0);
        step();
        idle_inputs();
        check_eq("fill_occ0b", 64'(occ(0)), 64'd16);
        check_eq("fill_head", 64'(bus.request_out), 64'hA0);
        check_eq("fill_chan", 64'(bus.request_channel_out), 64'h0);
        check_eq("fill_valid", 64'(bus.request_valid_out), 64'h1);

        // Round-robin drain of two entries per channel
        do_reset();
        bus.request_valid_in = 4'b1111;
        for (int c = 0; c < N; c++) set_data(c, 32'h10 * 32'(c + 1));
        step();
        check_eq("rr_lat0", 64'(bus.request_valid_out), 64'h0);
        for (int c = 0; c < N; c++) set_data(c, 32'h10 * 32'(c + 1) + 32'h1);
        step();
        idle_inputs();
        bus.issue_ack_in = 1'b1;
        for (int p = 0; p < 8; p++) begin
            check_eq($sformatf("rr_valid%0d", p), 64'(bus.request_valid_out), 64'h1);
            check_eq($sformatf("rr_chan%0d", p), 64'(bus.request_channel_out), 64'(p % 4));
            check_eq($sformatf("rr_data%0d", p), 64'(bus.request_out),
                     64'(32'h10 * 32'((p % 4) + 1) + 32'(p / 4)));
            step();
        end
        check_eq("rr_done", 64'(bus.request_valid_out), 64'h0);
        check_eq("rr_dout0", 64'(bus.request_out), 64'h0);
        check_eq("rr_empty", 64'(bus.is_empty_out), 64'hF);
        idle_inputs();

        // Flush the granted channel while acking
        do_reset();
        bus.request_valid_in = 4'b1100;
        set_data(2, 32'h55);
        set_data(3, 32'h66);
        step();
        idle_inputs();
        step();
        check_eq("fl_chan", 64'(bus.request_channel_out), 64'h2);
        check_eq("fl_data", 64'(bus.request_out), 64'h55);
        bus.flush_in     = 4'b0100;
        bus.issue_ack_in = 1'b1;
        step();
        idle_inputs();
        check_eq("fl_occ2", 64'(occ(2)), 64'h0);
        check_eq("fl_occ3", 64'(occ(3)), 64'h1);
        check_eq("fl_drop", 64'(bus.request_valid_out), 64'h0);
        step();
        check_eq("fl_valid", 64'(bus.request_valid_out), 64'h1);
        check_eq("fl_chan3", 64'(bus.request_channel_out), 64'h3);
        check_eq("fl_data3", 64'(bus.request_out), 64'h66);

        // Full channel refuses a write on the edge that pops it
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.request_valid_in = 4'b0010;
            set_data(1, 32'h100 + 32'(i));
            step();
        end
        idle_inputs();
        step();
        check_eq("fp_full", 64'(bus.is_full_out[1]), 64'h1);
        check_eq("fp_head", 64'(bus.request_out), 64'h100);
        bus.request_valid_in = 4'b0010;
        set_data(1, 32'h999);
        bus.issue_ack_in = 1'b1;
        #1;
        check_eq("fp_refuse", 64'(bus.issue_ack_out), 64'h0);
        step();
        idle_inputs();
        check_eq("fp_occ1", 64'(occ(1)), 64'd15);
        check_eq("fp_chan", 64'(bus.request_channel_out), 64'h1);
        check_eq("fp_next", 64'(bus.request_out), 64'h101);

        // Last entry of ch3 popped while ch0 is written: one-cycle gap
        do_reset();
        bus.request_valid_in = 4'b1000;
        set_data(3, 32'h77);
        step();
        idle_inputs();
        step();
        check_eq("gap_chan3", 64'(bus.request_channel_out), 64'h3);
        check_eq("gap_data3", 64'(bus.request_out), 64'h77);
        bus.issue_ack_in     = 1'b1;
        bus.request_valid_in = 4'b0001;
        set_data(0, 32'h88);
        step();
        idle_inputs();
        check_eq("gap_invalid", 64'(bus.request_valid_out), 64'h0);
        check_eq("gap_occ3", 64'(occ(3)), 64'h0);
        step();
        check_eq("gap_valid", 64'(bus.request_valid_out), 64'h1);
        check_eq("gap_chan0", 64'(bus.request_channel_out), 64'h0);
        check_eq("gap_data0", 64'(bus.request_out), 64'h88);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
